// File: rtl/qm_icache_ctrl.sv
// Direct-mapped instruction cache with a word-serial line refill FSM.
// Lookup is combinational; a miss in IDLE fetches the whole line, then fetch retries.
module qm_icache_ctrl #(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] icache_address,
  output logic        icache_hit,
  output logic        icache_should_stall,
  output logic [31:0] icache_data,
  input  logic        invalidate,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        refill_busy
);

  localparam int unsigned WordBits = $clog2(LINE_WORDS);
  localparam int unsigned Off      = WordBits + 2;
  localparam int unsigned Idx      = $clog2(LINES);
  localparam int unsigned TagW     = 32 - Off - Idx;

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e                state_q, state_d;
  logic [31:0]           base_q, base_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [WordBits-1:0]   cnt_q, cnt_d;
  logic                  kill_q, kill_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TagW-1:0]       tag_q [LINES];
  logic [31:0]           data_q [LINES*LINE_WORDS];

  logic [WordBits-1:0]   a_off;
  logic [Idx-1:0]        a_idx, b_idx;
  logic [TagW-1:0]       a_tag, b_tag;
  logic                  data_we, tag_we, last_word;
  logic                  unused_addr_bits;

  assign a_off = icache_address[Off-1:2];
  assign a_idx = icache_address[Off+Idx-1:Off];
  assign a_tag = icache_address[31:Off+Idx];
  assign b_idx = base_q[Off+Idx-1:Off];
  assign b_tag = base_q[31:Off+Idx];
  assign unused_addr_bits = ^{icache_address[1:0], base_q[Off-1:0]};

  assign icache_hit          = valid_q[a_idx] && (tag_q[a_idx] == a_tag) && (state_q == StIdle);
  assign icache_should_stall = !icache_hit;
  assign icache_data         = icache_hit ? data_q[{a_idx, a_off}] : 32'h0;
  assign mem_req             = (state_q == StFill);
  assign mem_addr            = mem_addr_q;
  assign refill_busy         = (state_q != StIdle);
  assign last_word           = (cnt_q == WordBits'(LINE_WORDS - 1));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    kill_d     = kill_q;
    valid_d    = valid_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        kill_d = 1'b0;
        if (invalidate) begin
          valid_d = '0;
        end else if (!icache_hit) begin
          base_d     = {icache_address[31:Off], {Off{1'b0}}};
          mem_addr_d = {icache_address[31:Off], {Off{1'b0}}};
          cnt_d      = '0;
          // The victim line is about to be partially overwritten.
          valid_d[a_idx] = 1'b0;
          state_d    = StFill;
        end
      end
      StFill: begin
        if (mem_ack) begin
          data_we    = 1'b1;
          cnt_d      = cnt_q + WordBits'(1);
          mem_addr_d = base_q | {{(30 - WordBits){1'b0}}, cnt_d, 2'b00};
          if (last_word) begin
            tag_we = 1'b1;
            if (!kill_q) valid_d[b_idx] = 1'b1;
            state_d = StDone;
          end
        end
        // Applied last so a same-cycle invalidate beats the final fill.
        if (invalidate) begin
          valid_d = '0;
          kill_d  = 1'b1;
        end
      end
      StDone: begin
        kill_d  = 1'b0;
        state_d = StIdle;
        if (invalidate) valid_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      kill_q     <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
      kill_q     <= kill_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (data_we) data_q[{b_idx, cnt_q}] <= mem_data;
    if (tag_we)  tag_q[b_idx] <= b_tag;
  end

endmodule

// File: tb/tb_qm_icache_ctrl.sv
// Self-checking bench for qm_icache_ctrl: a queue of expected bus addresses is
// checked by the memory responder, plus a lookup vector table and refill sequences.
module tb_qm_icache_ctrl;

  logic        sys_clk;
  logic        sys_rst;
  logic [31:0] icache_address;
  logic        icache_hit;
  logic        icache_should_stall;
  logic [31:0] icache_data;
  logic        invalidate;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        refill_busy;

  qm_icache_ctrl #(
    .LINES      (64),
    .LINE_WORDS (4)
  ) dut (
    .sys_clk             (sys_clk),
    .sys_rst             (sys_rst),
    .icache_address      (icache_address),
    .icache_hit          (icache_hit),
    .icache_should_stall (icache_should_stall),
    .icache_data         (icache_data),
    .invalidate          (invalidate),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .mem_ack             (mem_ack),
    .mem_data            (mem_data),
    .refill_busy         (refill_busy)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    logic [31:0] data;
  } vec_t;

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];
  logic [31:0] mem_seed;
  int          ack_period;
  int          req_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: memory responder acts on the falling edge, then step past the rising edge.
  task automatic cyc();
    @(negedge sys_clk);
    if (mem_req === 1'b1) begin
      if (exp_q.size() == 0) chk("mem_req_spurious", 32'd1, 32'd0);
      else chk("mem_addr", mem_addr, exp_q[0]);
      req_cyc++;
      if (req_cyc % ack_period == 0) begin
        mem_ack  = 1'b1;
        mem_data = mem_seed + {30'b0, mem_addr[3:2]};
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      mem_ack = 1'b0;
      req_cyc = 0;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_miss(input string name, input logic [31:0] addr, input logic [31:0] seed,
                          input int period, input int exp_lat, input logic [31:0] exp_data);
    int n;
    bit stall_ok;
    bit busy_seen;
    icache_address = addr;
    mem_seed       = seed;
    ack_period     = period;
    for (int i = 0; i < 4; i++) exp_q.push_back({addr[31:4], 4'b0} + 32'(4 * i));
    #1;
    stall_ok  = (icache_should_stall === 1'b1) && (icache_hit === 1'b0);
    busy_seen = 1'b0;
    n = 0;
    while (icache_hit !== 1'b1 && n < 40) begin
      cyc();
      n++;
      if (refill_busy === 1'b1) busy_seen = 1'b1;
      if (icache_hit !== 1'b1 && icache_should_stall !== 1'b1) stall_ok = 1'b0;
    end
    chk({name, "_latency"}, 32'(n), 32'(exp_lat));
    chk({name, "_data"}, icache_data, exp_data);
    chk({name, "_stall"}, {31'b0, stall_ok}, 32'd1);
    chk({name, "_busy"}, {31'b0, busy_seen}, 32'd1);
    chk({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{32'h0000_100C, 1'b1, 32'h0000_00A3};
    vecs[1] = '{32'h0000_1000, 1'b1, 32'h0000_00A0};
    vecs[2] = '{32'h0000_1004, 1'b1, 32'h0000_00A1};
    vecs[3] = '{32'h0000_100B, 1'b1, 32'h0000_00A2};
    vecs[4] = '{32'h0000_2008, 1'b0, 32'h0000_0000};
    vecs[5] = '{32'h0000_1018, 1'b0, 32'h0000_0000};
    vecs[6] = '{32'h0000_1408, 1'b0, 32'h0000_0000};

    checks = 0; failures = 0; req_cyc = 0; ack_period = 1; mem_seed = 32'h0;
    sys_rst = 1'b1; icache_address = 32'h0; invalidate = 1'b0;
    mem_ack = 1'b0; mem_data = 32'h0;
    cyc(); cyc();
    sys_rst = 1'b0;
    #1;
    chk("rst_hit", {31'b0, icache_hit}, 32'd0);
    chk("rst_stall", {31'b0, icache_should_stall}, 32'd1);
    chk("rst_data", icache_data, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_busy", {31'b0, refill_busy}, 32'd0);

    run_miss("cold", 32'h0000_1008, 32'hA0, 1, 6, 32'hA2);

    for (int i = 0; i < 7; i++) begin
      icache_address = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_hit", i), {31'b0, icache_hit}, {31'b0, vecs[i].hit});
      chk($sformatf("vec%0d_data", i), icache_data, vecs[i].data);
    end
    icache_address = 32'h0000_100C;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hit_hold", {31'b0, icache_hit}, 32'd1);
      chk("hit_no_req", {30'b0, mem_req, refill_busy}, 32'd0);
    end

    run_miss("conflict", 32'h0000_1408, 32'hB0, 1, 6, 32'hB2);
    icache_address = 32'h0000_1008;
    #1;
    chk("conflict_evict", {31'b0, icache_hit}, 32'd0);
    run_miss("refetch", 32'h0000_1008, 32'hA0, 1, 6, 32'hA2);

    run_miss("waitst", 32'h0000_201C, 32'hC0, 3, 14, 32'hC3);

    // Invalidate in IDLE with a missing address: no refill may start.
    icache_address = 32'h0000_3020;
    invalidate = 1'b1;
    cyc();
    invalidate = 1'b0;
    chk("inv_idle_busy", {31'b0, refill_busy}, 32'd0);
    icache_address = 32'h0000_201C;
    #1;
    chk("inv_idle_cleared", {31'b0, icache_hit}, 32'd0);

    // Invalidate on the second FILL cycle kills the refill.
    icache_address = 32'h0000_3020;
    mem_seed = 32'hD0; ack_period = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_3020 + 32'(4 * i));
    cyc();
    cyc();
    invalidate = 1'b1;
    cyc();
    invalidate = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("kill_idle", {31'b0, refill_busy}, 32'd0);
    chk("kill_words_left", 32'(exp_q.size()), 32'd0);
    chk("kill_not_valid", {31'b0, icache_hit}, 32'd0);
    run_miss("kill_retry", 32'h0000_3020, 32'hD0, 1, 6, 32'hD0);

    // Reset lands while the third word is on the bus.
    icache_address = 32'h0000_4034;
    mem_seed = 32'hE0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_4030 + 32'(4 * i));
    cyc();
    cyc();
    cyc();
    sys_rst = 1'b1;
    cyc();
    chk("rstmid_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rstmid_busy", {31'b0, refill_busy}, 32'd0);
    sys_rst = 1'b0;
    exp_q.delete();
    #1;
    chk("rstmid_invalid", {31'b0, icache_hit}, 32'd0);
    run_miss("rstmid_retry", 32'h0000_4034, 32'hE0, 1, 6, 32'hE1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qm_icache_ctrl.md
Name: qm_icache_ctrl

Overview:
- Direct-mapped instruction cache and refill controller sitting between the fetch stage and the memory bus.
- Serves the fetch stage's icache_address combinationally with hit/should_stall/data.
- On a miss, runs a refill FSM that pulls one full line from memory word by word, writes tag and valid, then lets fetch retry.
- Provides the icache_* signals that the fetch stage consumes.

Parameters:
- LINES, 64, number of cache lines; power of two, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2.
- Derived: OFF = log2(LINE_WORDS)+2, IDX = log2(LINES), TAG = 32-OFF-IDX.

Ports:
- sys_clk  in  1  clock; all state updates on rising edge.
- sys_rst  in  1  reset; synchronous, active-high.
- icache_address  in  32  fetch PC; bits [1:0] ignored.
- icache_hit  out  1  addressed word is present.
- icache_should_stall  out  1  fetch must hold PC (asserted on any miss).
- icache_data  out  32  addressed word; 0 when !icache_hit.
- invalidate  in  1  clear all valid bits.
- mem_req  out  1  memory read request, held until last word acked.
- mem_addr  out  32  word-aligned read address.
- mem_ack  in  1  mem_data valid this cycle; ignored when mem_req=0.
- mem_data  in  32  read data.
- refill_busy  out  1  FSM not IDLE.

Behaviour:
- Address split: offset = addr[OFF-1:2], index = addr[OFF+IDX-1:OFF], tag = addr[31:OFF+IDX].
- Storage: valid[LINES] (reset to 0), tag[LINES] and data[LINES*LINE_WORDS] (not reset); combinational read.
- icache_hit = valid[index] && tag[index]==tag && state==IDLE.
- icache_should_stall = !icache_hit.
- icache_data = hit ? data word : 32'h0.
- Reset values: state=IDLE, mem_req=0, mem_addr=0, refill_busy=0, all valid=0, word counter=0, kill flag=0.
- FSM:
  - IDLE: if !hit and !invalidate, latch line base {addr[31:OFF], OFF'b0}, counter=0 -> FILL. mem_req rises the next cycle with mem_addr=base.
  - FILL: mem_req=1, mem_addr = base + 4*counter.
    - On mem_ack: data[index][counter] <= mem_data and counter++.
    - On ack of word LINE_WORDS-1: write tag, set valid[index] unless kill flag set, drop mem_req the same edge -> DONE.
    - No ack: hold everything.
  - DONE: one bubble cycle, hit not reported -> IDLE. A retried PC hits on the following cycle.
- Miss-to-hit latency with zero-wait memory (ack every cycle in FILL): 1 (IDLE detect) + LINE_WORDS + 1 (DONE) = 6 cycles for LINE_WORDS=4.
- icache_address changes during FILL/DONE are ignored; the latched base is used.
- invalidate:
  - In IDLE: clears all valid bits at the edge; no refill starts that cycle.
  - In FILL/DONE: clears valid bits and sets the kill flag; the refill completes the bus transaction but does not set valid. Kill flag clears on return to IDLE.
- Simultaneous invalidate and final ack: invalidate wins; line stays invalid.
- sys_rst mid-refill: next edge returns to IDLE and mem_req=0 immediately; partial line stays invalid.
- Counter wraps exactly at LINE_WORDS; mem_addr never leaves the latched line.
- mem_req never deasserts inside FILL before the last ack.

Test Plan:
- Cold miss: after reset, addr=0x0000_1008, mem acks every cycle with data=0xA0+word -> mem_addr 0x1000,0x1004,0x1008,0x100C; icache_hit=1 and icache_data=0xA2 six cycles after the miss; should_stall=1 throughout.
- Hit after fill: addr=0x0000_100C -> hit=1, data=0xA3 same cycle, mem_req stays 0.
- Conflict: addr=0x0000_1408 (same index 0, tag 0x5 vs 0x4) -> miss, refill from 0x1400; afterwards 0x1008 misses again.
- Wait states: ack asserted every third cycle -> mem_addr holds until each ack; completion after 12 FILL cycles; data correct.
- Invalidate mid-fill: pulse invalidate on the 2nd FILL cycle -> all four reads still complete, valid not set, next cycle misses and restarts the refill.
- Reset mid-fill: sys_rst during the 3rd word -> mem_req=0 and refill_busy=0 the next cycle; the same address then misses and refills from the line base.
